// File: rtl/demux_9_5_tdm.sv
// demux_9_5_tdm: registered 1-to-9 TDM demultiplexer for WIDTH-bit words, addressed or frame-counter channel selection.
// Optional macro DEMUX_SEL_ERR_EN adds a registered out-of-range select error pulse on err.
module demux_9_5_tdm #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       sel,
  input  logic             din_valid,
  input  logic             frame_mode,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [WIDTH-1:0] q8,
  output logic [8:0]       q_valid,
  output logic [3:0]       chan,
  output logic             frame_done,
  output logic             err
);
  typedef enum logic {ADDR, FRAME} mode_e;
  mode_e                 mode;
  logic [8:0][WIDTH-1:0] q_q, q_d;
  logic [8:0]            q_valid_q, q_valid_d;
  logic [3:0]            chan_q, chan_d, tgt;
  logic                  frame_done_q, frame_done_d, accept;
  always_comb begin
    mode = frame_mode ? FRAME : ADDR;
    tgt = (mode == FRAME) ? (frame_sync ? 4'd0 : chan_q) : sel;
    accept = din_valid && (tgt <= 4'd8);
    for (int k = 0; k < 9; k++) q_d[k] = (accept && tgt == 4'(k)) ? din : q_q[k];
    q_valid_d = accept ? (9'd1 << tgt) : 9'd0;
    chan_d = chan_q;
    frame_done_d = 1'b0;
    if (mode == FRAME) begin
      // frame_sync without a word still realigns the sweep to channel 0
      chan_d = accept ? ((tgt == 4'd8) ? 4'd0 : tgt + 4'd1) : (frame_sync ? 4'd0 : chan_q);
      frame_done_d = accept && (tgt == 4'd8);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
      q_valid_q <= '0;
      chan_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      q_q <= q_d;
      q_valid_q <= q_valid_d;
      chan_q <= chan_d;
      frame_done_q <= frame_done_d;
    end
  end
`ifdef DEMUX_SEL_ERR_EN
  logic err_q, err_d;
  always_comb err_d = (mode == ADDR) && din_valid && (sel > 4'd8);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign q0 = q_q[0];
  assign q1 = q_q[1];
  assign q2 = q_q[2];
  assign q3 = q_q[3];
  assign q4 = q_q[4];
  assign q5 = q_q[5];
  assign q6 = q_q[6];
  assign q7 = q_q[7];
  assign q8 = q_q[8];
  assign q_valid = q_valid_q;
  assign chan = chan_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_demux_9_5_tdm.sv
// tb_demux_9_5_tdm: directed self-checking bench for demux_9_5_tdm.
module tb_demux_9_5_tdm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] din = '0;
  logic [3:0] sel = '0;
  logic       din_valid = 1'b0, frame_mode = 1'b0, frame_sync = 1'b0;
  logic [4:0] q0, q1, q2, q3, q4, q5, q6, q7, q8;
  logic [8:0] q_valid;
  logic [3:0] chan;
  logic       frame_done, err;
  logic [4:0] qs [9];
  int total = 0;
  int bad = 0;
`ifdef DEMUX_SEL_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif
  demux_9_5_tdm dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .din_valid(din_valid),
    .frame_mode(frame_mode), .frame_sync(frame_sync),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7), .q8(q8),
    .q_valid(q_valid), .chan(chan), .frame_done(frame_done), .err(err)
  );
  always #5 clk = ~clk;
  assign qs[0] = q0;
  assign qs[1] = q1;
  assign qs[2] = q2;
  assign qs[3] = q3;
  assign qs[4] = q4;
  assign qs[5] = q5;
  assign qs[6] = q6;
  assign qs[7] = q7;
  assign qs[8] = q8;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12 rst_n = 1'b1;
    // reset applies asynchronously, before the next edge
    frame_mode = 1'b0; sel = 4'd3; din = 5'd5; din_valid = 1'b1;
    step();
    chk("pre_rst_q3", 32'(q3), 32'd5);
    chk("pre_rst_qv", 32'(q_valid), 32'h008);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q3", 32'(q3), 32'd0);
    chk("rst_qv", 32'(q_valid), 32'd0);
    chk("rst_chan", 32'(chan), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    din_valid = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      sel = 4'(k); din = 5'(10 + k); din_valid = 1'b1;
      step();
      chk($sformatf("addr_qv%0d", k), 32'(q_valid), 32'(9'd1 << k));
      chk($sformatf("addr_q%0d", k), 32'(qs[k]), 32'(10 + k));
    end
    din_valid = 1'b0;
    step();
    chk("addr_idle_qv", 32'(q_valid), 32'd0);
    for (int k = 0; k < 9; k++) chk($sformatf("addr_hold_q%0d", k), 32'(qs[k]), 32'(10 + k));
    sel = 4'hC; din = 5'h1F; din_valid = 1'b1;
    step();
    chk("oor_qv", 32'(q_valid), 32'd0);
    chk("oor_err", 32'(err), 32'(ERR_EXP));
    for (int k = 0; k < 9; k++) chk($sformatf("oor_q%0d", k), 32'(qs[k]), 32'(10 + k));
    din_valid = 1'b0;
    step();
    chk("oor_err_clr", 32'(err), 32'd0);
    frame_mode = 1'b1;
    for (int k = 0; k < 9; k++) begin
      din = 5'(k + 1); frame_sync = (k == 0); din_valid = 1'b1;
      step();
      chk($sformatf("frm_qv%0d", k), 32'(q_valid), 32'(9'd1 << k));
      chk($sformatf("frm_chan%0d", k), 32'(chan), (k == 8) ? 32'd0 : 32'(k + 1));
      chk($sformatf("frm_fd%0d", k), 32'(frame_done), (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("frm_err%0d", k), 32'(err), 32'd0);
    end
    frame_sync = 1'b0; din_valid = 1'b0;
    step();
    chk("frm_fd_clr", 32'(frame_done), 32'd0);
    for (int k = 0; k < 9; k++) chk($sformatf("frm_q%0d", k), 32'(qs[k]), 32'(k + 1));
    for (int k = 0; k < 5; k++) begin
      din = 5'(21 + k); frame_sync = (k == 0); din_valid = 1'b1;
      step();
    end
    chk("gap_chan_start", 32'(chan), 32'd5);
    frame_sync = 1'b0; din_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("gap_chan%0d", k), 32'(chan), 32'd5);
      chk($sformatf("gap_qv%0d", k), 32'(q_valid), 32'd0);
    end
    din = 5'd7; frame_sync = 1'b1; din_valid = 1'b1;
    step();
    chk("resync_q0", 32'(q0), 32'd7);
    chk("resync_chan", 32'(chan), 32'd1);
    chk("resync_q5", 32'(q5), 32'd6);
    chk("resync_q4", 32'(q4), 32'd25);
    chk("resync_qv", 32'(q_valid), 32'h001);
    din_valid = 1'b0;
    step();
    chk("sync_only_chan", 32'(chan), 32'd0);
    chk("sync_only_qv", 32'(q_valid), 32'd0);
    frame_sync = 1'b0; din_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = 5'(k + 1);
      step();
    end
    chk("mid_chan", 32'(chan), 32'd4);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_chan", 32'(chan), 32'd0);
    chk("mid_rst_q0", 32'(q0), 32'd0);
    #1 rst_n = 1'b1;
    din = 5'd3; din_valid = 1'b1;
    step();
    chk("post_rst_q0", 32'(q0), 32'd3);
    chk("post_rst_chan", 32'(chan), 32'd1);
    chk("post_rst_qv", 32'(q_valid), 32'h001);
    frame_mode = 1'b0; sel = 4'd2; din = 5'd17; frame_sync = 1'b1;
    step();
    chk("addr_q2", 32'(q2), 32'd17);
    chk("addr_chan_hold", 32'(chan), 32'd1);
    chk("addr_fd", 32'(frame_done), 32'd0);
    din_valid = 1'b0; frame_sync = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_9_5_tdm.md
# demux_9_5_tdm

Registered 1-to-9 time-division demultiplexer for 5-bit words, the receive-side counterpart of the 9-input, 5-bit channel multiplexer. It takes one word stream plus a channel code and distributes each word into one of nine holding registers, with per-channel update strobes. Channels are chosen either by an explicit select code (addressed mode) or by an internal channel counter that sweeps 0..8 (frame mode).

## Interface
- WIDTH, 5, data word width; applies to din and every q output.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  WIDTH  incoming word.
- sel  in  4  channel code; used only in addressed mode; valid range 4'h0..4'h8.
- din_valid  in  1  din (and sel) are valid this cycle.
- frame_mode  in  1  0 = addressed mode, 1 = frame mode.
- frame_sync  in  1  frame mode only: restart counter at channel 0.
- q0..q8  out  WIDTH each  channel holding registers.
- q_valid  out  9  bit k pulses one cycle when qk is updated.
- chan  out  4  current frame counter value, 0..8.
- frame_done  out  1  one-cycle pulse when channel 8 is written in frame mode.
- err  out  1  out-of-range select pulse (see Configuration).

## Operation
- Target channel t: addressed mode t = sel; frame mode t = 0 if frame_sync = 1, else chan.
- Write accepted on a clk edge with din_valid = 1 and t <= 8. On acceptance: qt <= din, q_valid <= one-hot(t), all other q registers hold.
- No accepted write: q_valid <= 0, all q registers hold.
- Addressed mode, sel in 4'h9..4'hF: word discarded; no q register or q_valid bit changes.
- Frame counter (two states, ADDR and FRAME, selected directly by frame_mode; no other states):
  - FRAME, accepted write: chan <= (t == 8) ? 0 : t + 1; frame_done <= (t == 8).
  - FRAME, frame_sync = 1, din_valid = 0: chan <= 0, no write.
  - FRAME, frame_sync = 0, din_valid = 0: chan holds.
  - ADDR: chan holds its value, frame_done = 0, frame_sync ignored.
- Switching ADDR -> FRAME resumes from the held chan; the source asserts frame_sync with the first word to align.
- frame_sync and din_valid in the same cycle: word goes to q0, chan <= 1.

## Timing
- Reset (rst_n = 0, asynchronous, effective immediately): q0..q8 = 0, q_valid = 0, chan = 0, frame_done = 0, err = 0. Reset asserted mid-frame discards the frame; the first accepted word after release goes to channel 0 in frame mode.
- Latency 1 cycle: word sampled at edge N is visible on qt, with q_valid[t] = 1 and frame_done/err where applicable, after edge N.
- Throughput: one word per cycle, back-to-back, no stall; no backpressure output.
- All outputs registered; no combinational path from inputs to outputs.
- q_valid is at most one-hot; frame_done coincides with q_valid[8].

## Configuration
- DEMUX_SEL_ERR_EN defined: err pulses high for one cycle after any edge where addressed mode, din_valid = 1 and sel > 4'h8. Frame mode never raises err.
- DEMUX_SEL_ERR_EN undefined: err tied to 0, no error register; discard behaviour is unchanged.

## Test plan
- Reset: drive inputs non-zero, pulse rst_n low between edges -> all outputs 0 at once, before the next edge.
- Addressed sweep: frame_mode = 0; sel = 0..8 with din = 5'd10..5'd18 back-to-back -> qk = 10+k, q_valid sequence 9'h001, 9'h002, ... 9'h100, one cycle after each word.
- Out-of-range: sel = 4'hC, din = 5'h1F, din_valid = 1 -> q registers unchanged, q_valid = 0; err = 1 for one cycle only with DEMUX_SEL_ERR_EN.
- Frame: frame_mode = 1, frame_sync with first word, 9 words 5'd1..5'd9 -> q0..q8 = 1..9, chan wraps 8 -> 0, frame_done = 1 exactly with q_valid[8].
- Frame gaps and resync: din_valid low for 3 cycles mid-frame -> chan holds; frame_sync with din = 5'd7 at chan = 5 -> q0 = 7, chan = 1, q5 unchanged.
- Reset mid-frame: rst_n low at chan = 4, release, next frame-mode word 5'd3 without frame_sync -> q0 = 3, chan = 1.
